// File: rtl/reg_wr_arbiter.sv
// ---------------------------------------------------------------------------
// reg_wr_arbiter
//   Round-robin arbiter in front of the single register file write port.
//   NUM_REQ writeback sources (ALU result, load data, link address, ...)
//   compete for the port. The winner is captured into an output register
//   that drives reg_file wr_en/wr_reg/wr_data for one cycle.
//
// Handshake (valid/ready):
//   A transfer from requester i happens on a rising clk edge where
//   req_valid[i] & req_ready[i]. The requester holds req_valid, req_reg and
//   req_data stable until that transfer, and req_valid never depends on
//   req_ready. req_ready is combinational from req_valid, stall and the
//   round-robin pointer only, and at most one bit is set per cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   stall      in   1 = accept no new requests this cycle
//   req_valid  in   per-requester write request
//   req_reg    in   packed dest reg, requester i at [i*REG_W +: REG_W]
//   req_data   in   packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  one-hot (or zero) accept strobe
//   wr_en      out  reg_file write enable (one cycle per non-x0 transfer)
//   wr_reg     out  reg_file write index
//   wr_data    out  reg_file write data
//   grant_id   out  requester whose write is currently on wr_*
// ---------------------------------------------------------------------------
module reg_wr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*REG_W-1:0]  req_reg,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      wr_en,
   output logic [REG_W-1:0]          wr_reg,
   output logic [DATA_W-1:0]         wr_data,
   output logic [ID_W-1:0]           grant_id
);

   logic [ID_W-1:0]   r_ptr;
   logic              r_wr_en;
   logic [REG_W-1:0]  r_wr_reg;
   logic [DATA_W-1:0] r_wr_data;
   logic [ID_W-1:0]   r_grant_id;

   logic              w_found;
   logic [ID_W-1:0]   w_win;
   logic [ID_W:0]     w_sum;
   logic [ID_W-1:0]   w_idx;
   logic              w_xfer;
   logic [REG_W-1:0]  w_sel_reg;
   logic [DATA_W-1:0] w_sel_data;
   logic [ID_W-1:0]   w_next_ptr;

   // Search from r_ptr upwards, wrapping modulo NUM_REQ; first valid wins.
   // w_sum is one bit wider so ptr+k never overflows before the wrap.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
         if (w_sum >= (ID_W+1)'(NUM_REQ))
            w_sum = w_sum - (ID_W+1)'(NUM_REQ);
         w_idx = w_sum[ID_W-1:0];
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_xfer     = w_found && !stall && !rst;
   assign w_sel_reg  = req_reg[w_win*REG_W +: REG_W];
   assign w_sel_data = req_data[w_win*DATA_W +: DATA_W];
   assign w_next_ptr = (w_win == ID_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;

   always_comb begin
      req_ready = '0;
      if (w_xfer)
         req_ready[w_win] = 1'b1;
   end

   // Output register: a transfer is presented on wr_* for exactly the next
   // cycle. An accepted x0 write still completes and advances the pointer,
   // but wr_en stays low so reg_file drops it. Without a transfer only
   // wr_en falls; index, data and grant_id keep their last captured values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr      <= '0;
         r_wr_en    <= 1'b0;
         r_wr_reg   <= '0;
         r_wr_data  <= '0;
         r_grant_id <= '0;
      end else begin
         r_wr_en <= 1'b0;
         if (w_xfer) begin
            r_wr_en    <= (w_sel_reg != '0);
            r_wr_reg   <= w_sel_reg;
            r_wr_data  <= w_sel_data;
            r_grant_id <= w_win;
            r_ptr      <= w_next_ptr;
         end
      end
   end

   assign wr_en    = r_wr_en;
   assign wr_reg   = r_wr_reg;
   assign wr_data  = r_wr_data;
   assign grant_id = r_grant_id;

endmodule
